// File: rtl/fp_add_pipe.sv
// rtl/fp_add_pipe.sv - 4-stage pipelined IEEE-754 adder (RNE, flush-to-zero, valid/ready)
// Define FP_ADD_SUB_OP_EN to add the in_op port (1 = compute A-B).
module fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
`ifdef FP_ADD_SUB_OP_EN
  input  logic         in_op,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic [2:0]   out_flags
);

  localparam int SIG_W = MAN_W + 1;
  localparam int ALN_W = MAN_W + 4;
  localparam int SUM_W = MAN_W + 5;
  localparam int SH_W  = $clog2(ALN_W);
  localparam int LZ_W  = $clog2(SUM_W + 1);
  localparam int EW2   = EXP_W + 2;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  logic adv;
  logic b_neg;

`ifdef FP_ADD_SUB_OP_EN
  assign b_neg = in_op;
`else
  assign b_neg = 1'b0;
`endif

  assign in_ready = ~(out_valid & ~out_ready);
  assign adv      = in_ready;

  // S1 unpack / classify / swap
  logic [EXP_W-1:0] ea, eb;
  logic             a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, a_big;
  logic [W-2:0]     mag_a, mag_b, mag_big, mag_sml;
  logic             c1_sb, c1_sign, c1_sub, c1_spec;
  logic [EXP_W-1:0] c1_exp, c1_d;
  logic [SIG_W-1:0] c1_big_sig, c1_sml_sig;
  logic [W-1:0]     c1_spec_res;
  logic [2:0]       c1_spec_flags;

  always_comb begin
    c1_sb      = in_b[W-1] ^ b_neg;
    ea         = in_a[W-2:MAN_W];
    eb         = in_b[W-2:MAN_W];
    a_zero     = (ea == '0);
    b_zero     = (eb == '0);
    a_nan      = (ea == EMAX) && (in_a[MAN_W-1:0] != '0);
    b_nan      = (eb == EMAX) && (in_b[MAN_W-1:0] != '0);
    a_inf      = (ea == EMAX) && (in_a[MAN_W-1:0] == '0);
    b_inf      = (eb == EMAX) && (in_b[MAN_W-1:0] == '0);
    mag_a      = a_zero ? '0 : in_a[W-2:0];
    mag_b      = b_zero ? '0 : in_b[W-2:0];
    a_big      = (mag_a >= mag_b);
    mag_big    = a_big ? mag_a : mag_b;
    mag_sml    = a_big ? mag_b : mag_a;
    c1_sign    = a_big ? in_a[W-1] : c1_sb;
    c1_sub     = in_a[W-1] ^ c1_sb;
    c1_exp     = mag_big[W-2:MAN_W];
    c1_d       = mag_big[W-2:MAN_W] - mag_sml[W-2:MAN_W];
    // Flushed operands have a zero exponent, so the hidden bit comes out 0.
    c1_big_sig = {|mag_big[W-2:MAN_W], mag_big[MAN_W-1:0]};
    c1_sml_sig = {|mag_sml[W-2:MAN_W], mag_sml[MAN_W-1:0]};

    c1_spec       = 1'b1;
    c1_spec_res   = QNAN;
    c1_spec_flags = 3'b000;
    if (a_nan || b_nan) begin
      c1_spec_res = QNAN;
    end else if (a_inf && b_inf && (in_a[W-1] != c1_sb)) begin
      c1_spec_flags = 3'b001;
    end else if (a_inf) begin
      c1_spec_res = {in_a[W-1], EMAX, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      c1_spec_res = {c1_sb, EMAX, {MAN_W{1'b0}}};
    end else if (a_zero && b_zero) begin
      c1_spec_res = {in_a[W-1] & c1_sb, {(W-1){1'b0}}};
    end else begin
      c1_spec = 1'b0;
    end
  end

  logic             s1_v, s1_sign, s1_sub, s1_spec;
  logic [EXP_W-1:0] s1_exp, s1_d;
  logic [SIG_W-1:0] s1_big_sig, s1_sml_sig;
  logic [W-1:0]     s1_spec_res;
  logic [2:0]       s1_spec_flags;

  // S2 align with guard/round/sticky
  logic [SH_W-1:0]  c2_sh;
  logic [ALN_W-1:0] c2_ext, c2_aligned, c2_sml;
  logic             c2_lost;

  always_comb begin
    c2_sh      = (int'(s1_d) > MAN_W + 3) ? SH_W'(MAN_W + 3) : SH_W'(s1_d);
    c2_ext     = {s1_sml_sig, 3'b000};
    c2_aligned = c2_ext >> c2_sh;
    c2_lost    = |(c2_ext & ~({ALN_W{1'b1}} << c2_sh));
    c2_sml     = c2_aligned | {{(ALN_W-1){1'b0}}, c2_lost};
  end

  logic             s2_v, s2_sign, s2_sub, s2_spec;
  logic [EXP_W-1:0] s2_exp;
  logic [ALN_W-1:0] s2_big, s2_sml;
  logic [W-1:0]     s2_spec_res;
  logic [2:0]       s2_spec_flags;

  // S3 add/subtract and leading-zero count; big >= small so the result is never negative
  logic [SUM_W-1:0] c3_sum;
  logic [LZ_W-1:0]  c3_lz;

  always_comb begin
    c3_sum = s2_sub ? ({1'b0, s2_big} - {1'b0, s2_sml}) : ({1'b0, s2_big} + {1'b0, s2_sml});
    c3_lz  = LZ_W'(SUM_W);
    for (int i = 0; i < SUM_W; i++) begin
      if (c3_sum[i]) c3_lz = LZ_W'(SUM_W - 1 - i);
    end
  end

  logic             s3_v, s3_sign, s3_spec;
  logic [EXP_W-1:0] s3_exp;
  logic [SUM_W-1:0] s3_sum;
  logic [LZ_W-1:0]  s3_lz;
  logic [W-1:0]     s3_spec_res;
  logic [2:0]       s3_spec_flags;

  // S4 normalise (leading one to the MSB), round to nearest even, pack
  logic [SUM_W-1:0] c4_norm;
  logic             c4_g, c4_st, c4_rnd, c4_carry;
  logic [SIG_W-1:0] c4_sig;
  logic [EW2-1:0]   c4_exp;
  logic [W-1:0]     c4_sum;
  logic [2:0]       c4_flags;

  always_comb begin
    c4_norm  = s3_sum << s3_lz;
    c4_g     = c4_norm[3];
    c4_st    = |c4_norm[2:0];
    c4_rnd   = c4_g & (c4_st | c4_norm[4]);
    c4_sig   = c4_norm[SUM_W-1:4] + {{MAN_W{1'b0}}, c4_rnd};
    // A rounding carry wraps the significand to zero, clearing the hidden bit.
    c4_carry = ~c4_sig[MAN_W];
    c4_exp   = EW2'(s3_exp) + EW2'(1) - EW2'(s3_lz) + EW2'(c4_carry);

    c4_sum   = {s3_sign, c4_exp[EXP_W-1:0], c4_sig[MAN_W-1:0]};
    c4_flags = {1'b0, c4_g | c4_st, 1'b0};
    if (s3_spec) begin
      c4_sum   = s3_spec_res;
      c4_flags = s3_spec_flags;
    end else if (s3_sum == '0) begin
      c4_sum   = '0;
      c4_flags = 3'b000;
    end else if (c4_exp[EW2-1] || (c4_exp == '0)) begin
      c4_sum   = {s3_sign, {(W-1){1'b0}}};
      c4_flags = 3'b010;
    end else if (c4_exp >= EW2'(EMAX)) begin
      c4_sum   = {s3_sign, EMAX, {MAN_W{1'b0}}};
      c4_flags = 3'b110;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v <= 1'b0; s1_sign <= 1'b0; s1_sub <= 1'b0; s1_spec <= 1'b0;
      s1_exp <= '0; s1_d <= '0; s1_big_sig <= '0; s1_sml_sig <= '0;
      s1_spec_res <= '0; s1_spec_flags <= '0;
      s2_v <= 1'b0; s2_sign <= 1'b0; s2_sub <= 1'b0; s2_spec <= 1'b0;
      s2_exp <= '0; s2_big <= '0; s2_sml <= '0;
      s2_spec_res <= '0; s2_spec_flags <= '0;
      s3_v <= 1'b0; s3_sign <= 1'b0; s3_spec <= 1'b0;
      s3_exp <= '0; s3_sum <= '0; s3_lz <= '0;
      s3_spec_res <= '0; s3_spec_flags <= '0;
      out_valid <= 1'b0; out_sum <= '0; out_flags <= '0;
    end else if (adv) begin
      s1_v          <= in_valid;
      s1_sign       <= c1_sign;
      s1_sub        <= c1_sub;
      s1_spec       <= c1_spec;
      s1_exp        <= c1_exp;
      s1_d          <= c1_d;
      s1_big_sig    <= c1_big_sig;
      s1_sml_sig    <= c1_sml_sig;
      s1_spec_res   <= c1_spec_res;
      s1_spec_flags <= c1_spec_flags;

      s2_v          <= s1_v;
      s2_sign       <= s1_sign;
      s2_sub        <= s1_sub;
      s2_spec       <= s1_spec;
      s2_exp        <= s1_exp;
      s2_big        <= {s1_big_sig, 3'b000};
      s2_sml        <= c2_sml;
      s2_spec_res   <= s1_spec_res;
      s2_spec_flags <= s1_spec_flags;

      s3_v          <= s2_v;
      s3_sign       <= s2_sign;
      s3_spec       <= s2_spec;
      s3_exp        <= s2_exp;
      s3_sum        <= c3_sum;
      s3_lz         <= c3_lz;
      s3_spec_res   <= s2_spec_res;
      s3_spec_flags <= s2_spec_flags;

      out_valid <= s3_v;
      if (s3_v) begin
        out_sum   <= c4_sum;
        out_flags <= c4_flags;
      end
    end
  end

endmodule
